// File: rtl/wb_arbiter_ctrl.sv
// Round-robin writeback arbiter: one buffered entry per requester, one register-file write per cycle.
// Optional per-channel wait counters are built only when WB_PERF_CNT_EN is defined.
module wb_arbiter_ctrl #(
  parameter int REQ_CHANNELS = 2,
  parameter int VEC_W        = 512,
  parameter int RID_W        = 3,
  parameter int VREG_W       = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [REQ_CHANNELS-1:0]        req_valid,
  output logic [REQ_CHANNELS-1:0]        req_ready,
  input  logic [REQ_CHANNELS*RID_W-1:0]  req_rid,
  input  logic [REQ_CHANNELS*VREG_W-1:0] req_vreg,
  input  logic [REQ_CHANNELS*VEC_W-1:0]  req_data,
  input  logic                           wb_hold,
  output logic                           rf_wen,
  output logic [RID_W+6-1:0]             rf_waddr,
  output logic [VEC_W-1:0]               rf_wdata,
  output logic                           wb_valid,
  output logic [RID_W-1:0]               wb_rid,
  output logic [VREG_W-1:0]              wb_vreg,
  output logic [REQ_CHANNELS*16-1:0]     perf_wait_cnt
);

  localparam int PTR_W = (REQ_CHANNELS > 1) ? $clog2(REQ_CHANNELS) : 1;
  localparam int AW    = RID_W + 6;

  logic [REQ_CHANNELS-1:0] buf_valid;
  logic [RID_W-1:0]        buf_rid  [REQ_CHANNELS];
  logic [VREG_W-1:0]       buf_vreg [REQ_CHANNELS];
  logic [VEC_W-1:0]        buf_data [REQ_CHANNELS];

  logic [PTR_W-1:0]        rr_ptr;
  logic [REQ_CHANNELS-1:0] gnt;
  logic [REQ_CHANNELS-1:0] accept;
  logic                    gnt_any;
  logic [PTR_W-1:0]        gnt_idx;
  logic [AW-1:0]           waddr_next;

  // First buffered channel at or after rr_ptr wins; wb_hold suppresses every grant.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (!wb_hold) begin
      for (int k = 0; k < REQ_CHANNELS; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= REQ_CHANNELS) idx = idx - REQ_CHANNELS;
        if (!gnt_any && buf_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = PTR_W'(idx);
        end
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  // A channel being drained this cycle can refill in the same cycle.
  always_comb begin
    req_ready = ~buf_valid | gnt;
    accept    = req_valid & req_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= '0;
    end else begin
      for (int i = 0; i < REQ_CHANNELS; i++) begin
        if (accept[i]) begin
          buf_valid[i] <= 1'b1;
          buf_rid[i]   <= req_rid[i*RID_W +: RID_W];
          buf_vreg[i]  <= req_vreg[i*VREG_W +: VREG_W];
          buf_data[i]  <= req_data[i*VEC_W +: VEC_W];
        end else if (gnt[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      if (int'(gnt_idx) == REQ_CHANNELS - 1) rr_ptr <= '0;
      else                                   rr_ptr <= gnt_idx + PTR_W'(1);
    end
  end

  // Register-file address is rid in the upper bits, vreg zero-extended into the low six.
  always_comb begin
    waddr_next = '0;
    if (gnt_any) begin
      waddr_next = (AW'(buf_rid[gnt_idx]) << 6) | AW'(buf_vreg[gnt_idx]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      wb_valid <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wb_rid   <= '0;
      wb_vreg  <= '0;
    end else begin
      rf_wen   <= gnt_any;
      wb_valid <= gnt_any;
      if (gnt_any) begin
        rf_waddr <= waddr_next;
        rf_wdata <= buf_data[gnt_idx];
        wb_rid   <= buf_rid[gnt_idx];
        wb_vreg  <= buf_vreg[gnt_idx];
      end
    end
  end

`ifdef WB_PERF_CNT_EN
  logic [15:0] wait_cnt [REQ_CHANNELS];

  // Counts cycles an entry sits buffered without a grant; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REQ_CHANNELS; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < REQ_CHANNELS; i++) begin
        if (buf_valid[i] && !gnt[i] && (wait_cnt[i] != 16'hFFFF)) begin
          wait_cnt[i] <= wait_cnt[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    perf_wait_cnt = '0;
    for (int i = 0; i < REQ_CHANNELS; i++) perf_wait_cnt[i*16 +: 16] = wait_cnt[i];
  end
`else
  assign perf_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter_ctrl.sv
// Directed bench for wb_arbiter_ctrl with two channels; expected values are hand-derived.
// Honours WB_PERF_CNT_EN when choosing the expected wait-counter value.
module tb_wb_arbiter_ctrl;

  localparam int N      = 2;
  localparam int VEC_W  = 512;
  localparam int RID_W  = 3;
  localparam int VREG_W = 6;

  logic                    clk;
  logic                    rst;
  logic [N-1:0]            req_valid;
  logic [N-1:0]            req_ready;
  logic [N*RID_W-1:0]      req_rid;
  logic [N*VREG_W-1:0]     req_vreg;
  logic [N*VEC_W-1:0]      req_data;
  logic                    wb_hold;
  logic                    rf_wen;
  logic [RID_W+6-1:0]      rf_waddr;
  logic [VEC_W-1:0]        rf_wdata;
  logic                    wb_valid;
  logic [RID_W-1:0]        wb_rid;
  logic [VREG_W-1:0]       wb_vreg;
  logic [N*16-1:0]         perf_wait_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_wait;

  wb_arbiter_ctrl #(
    .REQ_CHANNELS(N), .VEC_W(VEC_W), .RID_W(RID_W), .VREG_W(VREG_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rid(req_rid), .req_vreg(req_vreg), .req_data(req_data),
    .wb_hold(wb_hold),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_valid(wb_valid), .wb_rid(wb_rid), .wb_vreg(wb_vreg),
    .perf_wait_cnt(perf_wait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [VEC_W-1:0] observed,
                             input logic [VEC_W-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic setChannel(input int ch, input logic [RID_W-1:0] rid,
                            input logic [VREG_W-1:0] vreg, input logic [VEC_W-1:0] data);
    req_rid[ch*RID_W +: RID_W]    = rid;
    req_vreg[ch*VREG_W +: VREG_W] = vreg;
    req_data[ch*VEC_W +: VEC_W]   = data;
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic [N-1:0] valid, input logic hold);
    req_valid = valid;
    wb_hold   = hold;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; wb_hold = 1'b0;
    req_rid = '0; req_vreg = '0; req_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    $display("[TB] reset state");
    checkOutput("rst_wen", rf_wen, 0);
    checkOutput("rst_wbvalid", wb_valid, 0);
    checkOutput("rst_ready", req_ready, 2'b11);
    checkOutput("rst_waddr", rf_waddr, 0);
    checkOutput("rst_perf", perf_wait_cnt, 0);

    $display("[TB] single request on ch0");
    setChannel(0, 3'd2, 6'd5, 512'hA5);
    applyStimulus(2'b01, 1'b0);
    checkOutput("t1_wen_early", rf_wen, 0);
    applyStimulus(2'b00, 1'b0);
    checkOutput("t1_wen", rf_wen, 1);
    checkOutput("t1_wbvalid", wb_valid, 1);
    checkOutput("t1_waddr", rf_waddr, 133);
    checkOutput("t1_wdata", rf_wdata, 512'hA5);
    checkOutput("t1_rid", wb_rid, 2);
    checkOutput("t1_vreg", wb_vreg, 5);
    applyStimulus(2'b00, 1'b0);
    checkOutput("t1_wen_off", rf_wen, 0);
    checkOutput("t1_waddr_hold", rf_waddr, 133);

    // rr_ptr now points at ch1, so ch1 wins the first contended grant.
    $display("[TB] both channels streaming");
    setChannel(0, 3'd1, 6'd7, 512'h1111);
    setChannel(1, 3'd3, 6'd9, 512'h2222);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(2'b11, 1'b0);
      checkOutput("t2_ready", req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
      checkOutput("t2_wen", rf_wen, (k >= 2) ? 1 : 0);
      if (k >= 2) checkOutput("t2_rid", wb_rid, (k % 2 == 0) ? 3 : 1);
    end
    applyStimulus(2'b00, 1'b0);
    checkOutput("t2_drain0_rid", wb_rid, 1);
    checkOutput("t2_drain0_waddr", rf_waddr, 71);
    checkOutput("t2_drain0_wdata", rf_wdata, 512'h1111);
    applyStimulus(2'b00, 1'b0);
    checkOutput("t2_drain1_wen", rf_wen, 1);
    checkOutput("t2_drain1_waddr", rf_waddr, 201);
    checkOutput("t2_drain1_wdata", rf_wdata, 512'h2222);
    applyStimulus(2'b00, 1'b0);
    checkOutput("t2_idle_wen", rf_wen, 0);

    $display("[TB] hold with both buffers full");
    applyStimulus(2'b11, 1'b1);
    checkOutput("t3_ready_h0", req_ready, 2'b00);
    checkOutput("t3_wen_h0", rf_wen, 0);
    for (int k = 1; k <= 2; k++) begin
      applyStimulus(2'b00, 1'b1);
      checkOutput("t3_ready_h", req_ready, 2'b00);
      checkOutput("t3_wen_h", rf_wen, 0);
    end
    applyStimulus(2'b00, 1'b0);
    checkOutput("t3_rel0_wen", rf_wen, 1);
    checkOutput("t3_rel0_rid", wb_rid, 1);
    applyStimulus(2'b00, 1'b0);
    checkOutput("t3_rel1_rid", wb_rid, 3);
    checkOutput("t3_rel1_vreg", wb_vreg, 9);
    applyStimulus(2'b00, 1'b0);
    checkOutput("t3_idle_wen", rf_wen, 0);

    $display("[TB] reset with both buffers full");
    applyStimulus(2'b11, 1'b1);
    rst = 1'b1;
    applyStimulus(2'b00, 1'b1);
    rst = 1'b0;
    checkOutput("t4_wen", rf_wen, 0);
    checkOutput("t4_ready", req_ready, 2'b11);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b00, 1'b0);
      checkOutput("t4_no_write", rf_wen, 0);
    end

    $display("[TB] wait counter on ch1");
`ifdef WB_PERF_CNT_EN
    exp_wait = 16'd5;
`else
    exp_wait = 16'd0;
`endif
    applyStimulus(2'b10, 1'b1);
    for (int k = 0; k < 5; k++) applyStimulus(2'b00, 1'b1);
    checkOutput("t5_wait1", perf_wait_cnt[31:16], exp_wait);
    checkOutput("t5_wait0", perf_wait_cnt[15:0], 0);
    applyStimulus(2'b00, 1'b0);
    checkOutput("t5_rel_wen", rf_wen, 1);
    checkOutput("t5_rel_rid", wb_rid, 3);
    checkOutput("t5_wait1_after", perf_wait_cnt[31:16], exp_wait);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
